// File: rtl/exc_ctrl.sv
// Exception entry/return controller.
// Accepts exception requests, saves the return address to the banked r14,
// vectors the PC and handles exception return by restoring the CPSR from the
// banked SPSR of the current mode.
// Optional build macro: HIGH_VECTORS_EN selects the high vector base 0xFFFF_0000.
//
// state | meaning
// IDLE  | waiting for an exception request or an exception return
// SAVE  | r14 of the new mode is being written with the adjusted return address
// VECT  | PC is being written with the vector address, exc_ack pulses
// RET   | PC is being written with the return target, CPSR restored on exit
module exc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [2:0]  exc_type,
    input  logic [31:0] ret_addr,
    input  logic        ret_valid,
    input  logic [31:0] ret_pc,
    output logic [4:0]  M,
    output logic        write_reg,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data,
    output logic        write_pc,
    output logic [31:0] pc_data,
    output logic [31:0] cpsr,
    output logic        exc_ack,
    output logic        busy,
    output logic        err
);

`ifdef HIGH_VECTORS_EN
    localparam logic [31:0] VEC_BASE = 32'hFFFF_0000;
`else
    localparam logic [31:0] VEC_BASE = 32'h0000_0000;
`endif

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_VECT, S_RET} state_t;

    // Mode entered for each legal exception type.
    function automatic logic [4:0] target_mode(input logic [2:0] t);
        case (t)
            3'd1:    target_mode = MODE_UND;
            3'd2:    target_mode = MODE_SVC;
            3'd3:    target_mode = MODE_ABT;
            3'd4:    target_mode = MODE_ABT;
            3'd6:    target_mode = MODE_IRQ;
            3'd7:    target_mode = MODE_FIQ;
            default: target_mode = MODE_SVC;
        endcase
    endfunction

    // Offset added to the faulting PC before it lands in r14.
    function automatic logic [31:0] ret_offset(input logic [2:0] t);
        case (t)
            3'd3, 3'd6, 3'd7: ret_offset = 32'd4;
            3'd4:             ret_offset = 32'd8;
            default:          ret_offset = 32'd0;
        endcase
    endfunction

    // Banked SPSR slot for a mode; 5 means the mode has no SPSR.
    function automatic logic [2:0] spsr_idx(input logic [4:0] m);
        case (m)
            MODE_FIQ: spsr_idx = 3'd0;
            MODE_IRQ: spsr_idx = 3'd1;
            MODE_SVC: spsr_idx = 3'd2;
            MODE_ABT: spsr_idx = 3'd3;
            MODE_UND: spsr_idx = 3'd4;
            default:  spsr_idx = 3'd5;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  m_q, m_d;
    logic        i_q, i_d;
    logic        f_q, f_d;
    logic [6:0]  spsr_q [5];
    logic [6:0]  spsr_d [5];
    logic [2:0]  type_q, type_d;
    logic        write_reg_q, write_reg_d;
    logic [3:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        write_pc_q, write_pc_d;
    logic [31:0] pc_data_q, pc_data_d;
    logic        exc_ack_q, exc_ack_d;
    logic        err_q, err_d;

    logic        exc_legal;
    logic        exc_masked;
    logic [2:0]  tgt_idx;
    logic [2:0]  cur_idx;
    logic [4:0]  tgt_mode;

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        i_d         = i_q;
        f_d         = f_q;
        spsr_d      = spsr_q;
        type_d      = type_q;
        write_reg_d = 1'b0;
        w_addr_d    = 4'd0;
        w_data_d    = 32'd0;
        write_pc_d  = 1'b0;
        pc_data_d   = 32'd0;
        exc_ack_d   = 1'b0;
        err_d       = 1'b0;

        exc_legal  = (exc_type != 3'd0) && (exc_type != 3'd5);
        exc_masked = ((exc_type == 3'd6) && i_q) || ((exc_type == 3'd7) && f_q);
        tgt_mode   = target_mode(exc_type);
        tgt_idx    = spsr_idx(tgt_mode);
        cur_idx    = spsr_idx(m_q);

        case (state_q)
            S_IDLE: begin
                if (exc_valid && !exc_legal) begin
                    err_d = 1'b1;
                end else if (exc_valid && !exc_masked) begin
                    // Mode switches here so the r14 write hits the new bank.
                    if (tgt_idx < 3'd5) spsr_d[tgt_idx] = {i_q, f_q, m_q};
                    m_d         = tgt_mode;
                    i_d         = 1'b1;
                    if (exc_type == 3'd7) f_d = 1'b1;
                    type_d      = exc_type;
                    write_reg_d = 1'b1;
                    w_addr_d    = 4'd14;
                    w_data_d    = ret_addr + ret_offset(exc_type);
                    state_d     = S_SAVE;
                end else if (ret_valid) begin
                    // A masked pending request does not block a return.
                    if (cur_idx < 3'd5) begin
                        write_pc_d = 1'b1;
                        pc_data_d  = ret_pc;
                        state_d    = S_RET;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SAVE: begin
                write_pc_d = 1'b1;
                pc_data_d  = VEC_BASE + {27'd0, type_q, 2'b00};
                exc_ack_d  = 1'b1;
                state_d    = S_VECT;
            end
            S_VECT: begin
                state_d = S_IDLE;
            end
            S_RET: begin
                if (cur_idx < 3'd5) {i_d, f_d, m_d} = spsr_q[cur_idx];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            m_q         <= MODE_SVC;
            i_q         <= 1'b1;
            f_q         <= 1'b1;
            for (int k = 0; k < 5; k++) spsr_q[k] <= 7'd0;
            type_q      <= 3'd0;
            write_reg_q <= 1'b0;
            w_addr_q    <= 4'd0;
            w_data_q    <= 32'd0;
            write_pc_q  <= 1'b0;
            pc_data_q   <= 32'd0;
            exc_ack_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            i_q         <= i_d;
            f_q         <= f_d;
            spsr_q      <= spsr_d;
            type_q      <= type_d;
            write_reg_q <= write_reg_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            write_pc_q  <= write_pc_d;
            pc_data_q   <= pc_data_d;
            exc_ack_q   <= exc_ack_d;
            err_q       <= err_d;
        end
    end

    assign M         = m_q;
    assign cpsr      = {24'd0, i_q, f_q, 1'b0, m_q};
    assign busy      = (state_q != S_IDLE);
    assign write_reg = write_reg_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign write_pc  = write_pc_q;
    assign pc_data   = pc_data_q;
    assign exc_ack   = exc_ack_q;
    assign err       = err_q;

endmodule
